// File: rtl/dcache.sv
// Two-way set-associative write-back data cache, 8 sets of 2-word blocks.
// Halt flushes dirty frames, then writes the hit count to 0x3100.
module dcache (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);

    typedef enum logic [3:0] {
        IDLE, WB1, WB2, FETCH1, FETCH2,
        FLUSH, FWB1, FWB2, CNT, DONE
    } state_t;

    state_t state, nstate;

    logic [31:0]      data [2][8][2];
    logic [25:0]      tags [2][8];
    logic [1:0][7:0]  valid;
    logic [1:0][7:0]  dirty;
    logic [7:0]       lru;
    logic [31:0]      hcnt;
    logic [3:0]       fcnt;
    logic [25:0]      rtag;
    logic [2:0]       ridx;
    logic             vway;

    logic [25:0] atag;
    logic [2:0]  aidx;
    logic        ablk;
    logic        req, hit0, hit1, hit, hway;
    logic        vict, vdirty, miss;
    logic        fway, fdirty;
    logic [2:0]  fset;
    logic        unused_ok;

    assign atag      = dmemaddr[31:6];
    assign aidx      = dmemaddr[5:3];
    assign ablk      = dmemaddr[2];
    assign unused_ok = ^dmemaddr[1:0];
    assign req       = dmemREN | dmemWEN;
    assign hit0      = valid[0][aidx] && (tags[0][aidx] == atag);
    assign hit1      = valid[1][aidx] && (tags[1][aidx] == atag);
    assign hit       = hit0 | hit1;
    assign hway      = hit1;
    assign vict      = lru[aidx];
    assign vdirty    = valid[vict][aidx] & dirty[vict][aidx];
    assign fway      = fcnt[3];
    assign fset      = fcnt[2:0];
    assign fdirty    = valid[fway][fset] & dirty[fway][fset];

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= nstate;
    end

    // Next state and all bus/datapath outputs
    always_comb begin
        nstate   = state;
        dhit     = 1'b0;
        dmemload = 32'h0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'h0;
        dstore   = 32'h0;
        miss     = 1'b0;
        unique case (state)
            IDLE: begin
                if (halt) begin
                    nstate = FLUSH;
                end else if (req && hit) begin
                    dhit     = 1'b1;
                    dmemload = data[hway][aidx][ablk];
                end else if (req) begin
                    miss   = 1'b1;
                    nstate = vdirty ? WB1 : FETCH1;
                end
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = {tags[vway][ridx], ridx, 3'b000};
                dstore = data[vway][ridx][0];
                if (!dwait) nstate = WB2;
            end
            WB2: begin
                dWEN   = 1'b1;
                daddr  = {tags[vway][ridx], ridx, 3'b100};
                dstore = data[vway][ridx][1];
                if (!dwait) nstate = FETCH1;
            end
            FETCH1: begin
                dREN  = 1'b1;
                daddr = {rtag, ridx, 3'b000};
                if (!dwait) nstate = FETCH2;
            end
            FETCH2: begin
                dREN  = 1'b1;
                daddr = {rtag, ridx, 3'b100};
                if (!dwait) nstate = IDLE;
            end
            FLUSH: begin
                if (fdirty)             nstate = FWB1;
                else if (fcnt == 4'd15) nstate = CNT;
            end
            FWB1: begin
                dWEN   = 1'b1;
                daddr  = {tags[fway][fset], fset, 3'b000};
                dstore = data[fway][fset][0];
                if (!dwait) nstate = FWB2;
            end
            FWB2: begin
                dWEN   = 1'b1;
                daddr  = {tags[fway][fset], fset, 3'b100};
                dstore = data[fway][fset][1];
                if (!dwait) nstate = (fcnt == 4'd15) ? CNT : FLUSH;
            end
            CNT: begin
                dWEN   = 1'b1;
                daddr  = 32'h0000_3100;
                dstore = hcnt;
                if (!dwait) nstate = DONE;
            end
            DONE: flushed = 1'b1;
            default: nstate = IDLE;
        endcase
        if (RST) begin
            nstate   = IDLE;
            dhit     = 1'b0;
            dmemload = 32'h0;
            flushed  = 1'b0;
            dREN     = 1'b0;
            dWEN     = 1'b0;
            daddr    = 32'h0;
            dstore   = 32'h0;
            miss     = 1'b0;
        end
    end

    // Cache arrays, LRU, hit counter, miss and flush bookkeeping
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid <= '0;
            dirty <= '0;
            lru   <= '0;
            hcnt  <= '0;
            fcnt  <= '0;
            rtag  <= '0;
            ridx  <= '0;
            vway  <= 1'b0;
        end else begin
            if (dhit) begin
                hcnt      <= hcnt + 32'd1;
                lru[aidx] <= ~hway;
                if (dmemWEN) begin
                    data[hway][aidx][ablk] <= dmemstore;
                    dirty[hway][aidx]      <= 1'b1;
                end
            end
            if (miss) begin
                hcnt <= hcnt - 32'd1;
                vway <= vict;
                rtag <= atag;
                ridx <= aidx;
            end
            if (state == IDLE && halt) fcnt <= '0;
            if (state == FETCH1 && !dwait) data[vway][ridx][0] <= dload;
            if (state == FETCH2 && !dwait) begin
                data[vway][ridx][1] <= dload;
                tags[vway][ridx]    <= rtag;
                valid[vway][ridx]   <= 1'b1;
                dirty[vway][ridx]   <= 1'b0;
            end
            if (state == FLUSH && !fdirty) fcnt <= fcnt + 4'd1;
            if (state == FWB2 && !dwait) begin
                dirty[fway][fset] <= 1'b0;
                fcnt              <= fcnt + 4'd1;
            end
        end
    end

endmodule
